muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide instructions (funct7 = 1 on the OP opcode).
- Accepts one operation at a time from the decode/execute stage and runs a radix-2 shift-add multiplier or restoring divider over a shared 2*XLEN accumulator.
- Returns the result through a valid/ready handshake while the pipeline stalls on it.
- Sits beside the main ALU; the control unit asserts req_valid when it decodes an RVM instruction.

---
 rtl/muldiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide sequencer.
// One operation at a time; radix-2 shift-add multiply or restoring divide
// over a shared 2*XLEN accumulator, result returned via valid/ready.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_result,
    output logic            busy
);

    localparam int              CW      = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic [XLEN-1:0]     mcand_q;
    logic [2*XLEN-1:0]   acc_q;
    logic [CW-1:0]       cnt_q;

    logic                a_signed;
    logic                b_signed;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                div_zero;
    logic                div_ovf;
    logic                fast;
    logic [XLEN-1:0]     fast_result;

    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       trial;
    logic [2*XLEN-1:0]   acc_next;

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quot_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     final_result;

    // Request decode: operand signedness, magnitudes and divide special cases.
    always_comb begin
        a_signed = (req_op == OP_MULH) || (req_op == OP_MULHSU) ||
                   (req_op == OP_DIV)  || (req_op == OP_REM);
        b_signed = (req_op == OP_MULH) || (req_op == OP_DIV) || (req_op == OP_REM);
        a_neg    = a_signed && req_a[XLEN-1];
        b_neg    = b_signed && req_b[XLEN-1];
        a_mag    = a_neg ? -req_a : req_a;
        b_mag    = b_neg ? -req_b : req_b;
        div_zero = (req_b == '0);
        div_ovf  = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                   (req_a == MIN_INT) && (req_b == '1);
        fast     = req_op[2] && (div_zero || div_ovf);
        if (div_zero) begin
            fast_result = req_op[1] ? req_a : '1;
        end else begin
            fast_result = req_op[1] ? '0 : req_a;
        end
    end

    // One iteration step of the shift-add multiplier or restoring divider.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        // Remainder:quotient shifted left by one, remainder widened to XLEN+1
        // so the trial subtraction's sign bit tells whether the divisor fits.
        trial   = acc_q[2*XLEN-1:XLEN-1] - {1'b0, mcand_q};
        if (op_q[2]) begin
            if (!trial[XLEN]) begin
                acc_next = {trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_next = {acc_q[2*XLEN-2:0], 1'b0};
            end
        end else begin
            acc_next = {mul_sum, acc_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection applied to the last iteration's output.
    always_comb begin
        prod_fix = neg_res_q ? -acc_next : acc_next;
        quot_fix = neg_res_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem_fix  = neg_rem_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                        final_result = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  final_result = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               final_result = quot_fix;
            default:                       final_result = rem_fix;
        endcase
    end

    // Sequencer FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            resp_result <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!kill && req_valid) begin
                        op_q      <= req_op;
                        neg_res_q <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        mcand_q   <= b_mag;
                        acc_q     <= {{XLEN{1'b0}}, a_mag};
                        cnt_q     <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (fast) begin
                            state_q     <= DONE;
                            resp_valid  <= 1'b1;
                            resp_result <= fast_result;
                        end else begin
                            state_q <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (kill) begin
                        state_q   <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                        cnt_q     <= '0;
                    end else begin
                        acc_q <= acc_next;
                        if (cnt_q == LAST) begin
                            state_q     <= DONE;
                            resp_valid  <= 1'b1;
                            resp_result <= final_result;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (kill || resp_ready) begin
                        state_q    <= IDLE;
                        req_ready  <= 1'b1;
                        resp_valid <= 1'b0;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed RV32M vectors with literal
// expectations, plus an arithmetic reference model compared every cycle.
module tb_muldiv_seq;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a;
    logic [XLEN-1:0] req_b;
    logic            kill;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_result;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    // Reference model state: 0 idle, 1 computing, 2 result held
    int          m_phase  = 0;
    int          m_left   = 0;
    bit          m_valid  = 0;
    logic [31:0] m_result = '0;
    logic [31:0] m_pend   = '0;

    muldiv_seq #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .kill        (kill),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV32M semantics computed with plain wide arithmetic.
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        logic [63:0]     p;
        int              sa;
        int              sb;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; p = up; return p[31:0]; end
            3'd1: begin sp = longint'(sa) * longint'(sb); p = sp; return p[63:32]; end
            3'd2: begin sp = longint'(sa) * longint'({32'b0, b}); p = sp; return p[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; p = up; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] op, input logic [31:0] a,
                                      input logic [31:0] b);
        if (!op[2]) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // Model update on each rising edge from the sampled inputs.
    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_phase  = 0;
                m_valid  = 0;
                m_result = '0;
            end else begin
                case (m_phase)
                    0: if (!kill && req_valid) begin
                        m_pend = ref_op(req_op, req_a, req_b);
                        if (is_special(req_op, req_a, req_b)) begin
                            m_phase  = 2;
                            m_valid  = 1;
                            m_result = m_pend;
                        end else begin
                            m_phase = 1;
                            m_left  = XLEN;
                        end
                    end
                    1: begin
                        if (kill) begin
                            m_phase = 0;
                        end else begin
                            m_left = m_left - 1;
                            if (m_left == 0) begin
                                m_phase  = 2;
                                m_valid  = 1;
                                m_result = m_pend;
                            end
                        end
                    end
                    default: if (kill || resp_ready) begin
                        m_phase = 0;
                        m_valid = 0;
                    end
                endcase
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("model req_ready", 32'(req_ready), 32'(m_phase == 0));
                check("model busy", 32'(busy), 32'(m_phase != 0));
                check("model resp_valid", 32'(resp_valid), 32'(m_valid));
                if (m_valid) check("model resp_result", resp_result, m_result);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge with the DUT idle; returns after the accept edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        sync();
        req_valid = 1'b0;
    endtask

    // Counts cycles from the accept edge until resp_valid; ends on a falling edge.
    task automatic await_valid(input string name, input int exp_lat, input logic [31:0] exp_res);
        int lat;
        lat = 1;
        forever begin
            @(negedge clk);
            if (resp_valid) break;
            if (lat >= 100) break;
            @(posedge clk);
            lat++;
        end
        check($sformatf("%s latency", name), 32'(lat), 32'(exp_lat));
        check($sformatf("%s result", name), resp_result, exp_res);
    endtask

    task automatic consume;
        resp_ready = 1'b1;
        sync();
        resp_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res);
        issue(op, a, b);
        await_valid(name, exp_lat, exp_res);
        consume();
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_a      = '0;
        req_b      = '0;
        kill       = 1'b0;
        resp_ready = 1'b0;
        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd1);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset resp_result", resp_result, 32'h0);
        sync();

        run("MUL 7*-3",       3'd0, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFEB);
        run("MULH 7*-3",      3'd1, 32'd7,          32'hFFFF_FFFD, 33, 32'hFFFF_FFFF);
        run("MULHU max*max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'hFFFF_FFFE);
        run("MULHSU -1*max",  3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 33, 32'hFFFF_FFFF);
        run("MULH min*min",   3'd1, 32'h8000_0000,  32'h8000_0000, 33, 32'h4000_0000);
        run("MUL min*min",    3'd0, 32'h8000_0000,  32'h8000_0000, 33, 32'h0);
        run("DIV -20/6",      3'd4, 32'hFFFF_FFEC,  32'd6,         33, 32'hFFFF_FFFD);
        run("REM -20%6",      3'd6, 32'hFFFF_FFEC,  32'd6,         33, 32'hFFFF_FFFE);
        run("DIVU 20/6",      3'd5, 32'd20,         32'd6,         33, 32'd3);
        run("REMU 20%6",      3'd7, 32'd20,         32'd6,         33, 32'd2);
        run("DIV 7/-2",       3'd4, 32'd7,          32'hFFFF_FFFE, 33, 32'hFFFF_FFFD);
        run("REM 7%-2",       3'd6, 32'd7,          32'hFFFF_FFFE, 33, 32'd1);
        run("DIVU max/1",     3'd5, 32'hFFFF_FFFF,  32'd1,         33, 32'hFFFF_FFFF);
        run("DIV 5/0",        3'd4, 32'd5,          32'd0,          1, 32'hFFFF_FFFF);
        run("REMU 5%0",       3'd7, 32'd5,          32'd0,          1, 32'd5);
        run("DIV min/-1",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h8000_0000);
        run("REM min%-1",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  1, 32'h0);

        // Backpressure: result held, new request ignored while DONE.
        issue(3'd5, 32'd100, 32'd7);
        await_valid("DIVU 100/7", 33, 32'd14);
        req_valid = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd1;
        req_b     = 32'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("hold resp_valid", 32'(resp_valid), 32'd1);
            check("hold resp_result", resp_result, 32'd14);
            check("hold req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        consume();
        @(negedge clk);
        check("release req_ready", 32'(req_ready), 32'd1);
        check("release resp_valid", 32'(resp_valid), 32'd0);
        sync();

        // Kill at iteration 10 of a divide.
        issue(3'd4, 32'd1000, 32'd7);
        repeat (10) sync();
        kill = 1'b1;
        sync();
        kill = 1'b0;
        @(negedge clk);
        check("kill resp_valid", 32'(resp_valid), 32'd0);
        check("kill req_ready", 32'(req_ready), 32'd1);
        check("kill busy", 32'(busy), 32'd0);
        repeat (3) sync();
        run("MUL 3*4 after kill", 3'd0, 32'd3, 32'd4, 33, 32'd12);

        // Kill has priority over a request in IDLE.
        req_valid = 1'b1;
        kill      = 1'b1;
        req_op    = 3'd0;
        req_a     = 32'd2;
        req_b     = 32'd2;
        sync();
        req_valid = 1'b0;
        kill      = 1'b0;
        @(negedge clk);
        check("idle kill busy", 32'(busy), 32'd0);
        check("idle kill req_ready", 32'(req_ready), 32'd1);
        sync();

        // Reset while holding a result.
        issue(3'd4, 32'd5, 32'd0);
        await_valid("DIV 5/0 pre-reset", 1, 32'hFFFF_FFFF);
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clk);
        check("done reset resp_valid", 32'(resp_valid), 32'd0);
        check("done reset req_ready", 32'(req_ready), 32'd1);
        check("done reset resp_result", resp_result, 32'h0);
        sync();
        run("DIVU 20/6 after reset", 3'd5, 32'd20, 32'd6, 33, 32'd3);

        repeat (2) sync();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
